// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mcu_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      R_EXE  = 4'd2,
      I_EXE  = 4'd3,
      B_EXE  = 4'd4,
      LU_EXE = 4'd5,
      AU_EXE = 4'd6,
      J_EXE  = 4'd7,
      JL_EXE = 4'd8,
      S_EXE  = 4'd9,
      S_MEM  = 4'd10,
      L_EXE  = 4'd11,
      L_MEM  = 4'd12,
      L_WB   = 4'd13
   } state_t;

   localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
   localparam logic [6:0] OP_TYPE_IL = 7'b0000011;
   localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
   localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
   localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
   localparam logic [6:0] OP_TYPE_U  = 7'b0110111;
   localparam logic [6:0] OP_TYPE_UA = 7'b0010111;
   localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
   localparam logic [6:0] OP_TYPE_JI = 7'b1100111;

   localparam logic [2:0] IMM_I  = 3'b000;
   localparam logic [2:0] IMM_IA = 3'b001;
   localparam logic [2:0] IMM_S  = 3'b010;
   localparam logic [2:0] IMM_B  = 3'b011;
   localparam logic [2:0] IMM_U  = 3'b100;
   localparam logic [2:0] IMM_J  = 3'b101;

   localparam logic [1:0] RFWD_ALU  = 2'b00;
   localparam logic [1:0] RFWD_LOAD = 2'b01;
   localparam logic [1:0] RFWD_IMM  = 2'b10;
   localparam logic [1:0] RFWD_PC   = 2'b11;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   // Only the shift immediates carry a meaningful funct7[5] in I-type.
   function automatic logic is_shift_f3(input logic [2:0] funct3);
      return (funct3 == 3'b001) || (funct3 == 3'b101);
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction/data bus and datapath control bundle of the control unit.
interface multicycle_control_unit_if;
   logic [31:0] instr_code;
   logic        dataMem_ready;
   logic        pc_en;
   logic        regFile_wr_en;
   logic        AluSrcMuxSel;
   logic [1:0]  RFWriteDataSrcMuxSel;
   logic        dataMem_wr_en;
   logic        dataMem_req;
   logic [2:0]  immExtType;
   logic [1:0]  storeType;
   logic [2:0]  loadType;
   logic        Bbranch;
   logic        Jbranch;
   logic        JIbranch;
   logic [3:0]  ALUControl;
   logic        illegal_instr;
   logic [3:0]  state_o;

   modport master (
      output instr_code, dataMem_ready,
      input  pc_en, regFile_wr_en, AluSrcMuxSel, RFWriteDataSrcMuxSel,
             dataMem_wr_en, dataMem_req, immExtType, storeType, loadType,
             Bbranch, Jbranch, JIbranch, ALUControl, illegal_instr, state_o
   );

   modport slave (
      input  instr_code, dataMem_ready,
      output pc_en, regFile_wr_en, AluSrcMuxSel, RFWriteDataSrcMuxSel,
             dataMem_wr_en, dataMem_req, immExtType, storeType, loadType,
             Bbranch, Jbranch, JIbranch, ALUControl, illegal_instr, state_o
   );
endinterface

// File: rtl/mcu_alu_decoder.sv
// ALU operation select from instruction fields and the current sequencer state.
module mcu_alu_decoder
   import mcu_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  state_t     state,
   output logic [3:0] alu_control
);

   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   // Address-compute and non-ALU states fall back to ADD so the output is never X.
   always_comb begin
      alu_control = ALU_ADD;
      case (state)
         R_EXE:  if (op == OP_TYPE_R)  alu_control = {funct7[5], funct3};
         I_EXE:  if (op == OP_TYPE_I)  alu_control = is_shift_f3(funct3) ?
                                                     {funct7[5], funct3} : {1'b0, funct3};
         B_EXE:  if (op == OP_TYPE_B)  alu_control = {1'b0, funct3};
         JL_EXE: if (op == OP_TYPE_JI) alu_control = {1'b0, funct3};
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: one instruction over 3-5 cycles.
// Optional build macro BUS_READY_EN: memory states wait for dataMem_ready.
//
// state  | meaning
// FETCH  | instruction bus presents instr_code, no strobes
// DECODE | opcode dispatch; unknown opcode pulses illegal_instr and skips
// R_EXE  | register-register ALU op, write back, advance PC
// I_EXE  | register-immediate ALU op, write back, advance PC
// B_EXE  | branch compare, advance/branch PC, no write back
// LU_EXE | lui write back
// AU_EXE | auipc write back
// J_EXE  | jal link and jump
// JL_EXE | jalr link and jump
// S_EXE  | store address compute
// S_MEM  | store data write, advance PC
// L_EXE  | load address compute
// L_MEM  | load data read
// L_WB   | load write back, advance PC
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter state_t RESET_STATE = FETCH
)(
   input  logic                         clk,
   input  logic                         reset,
   multicycle_control_unit_if.slave     bus
);

   state_t     state;
   logic [6:0] op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       legal_op;
   logic       mem_go;
   logic [3:0] alu_control;

   assign op     = bus.instr_code[6:0];
   assign funct3 = bus.instr_code[14:12];
   assign funct7 = bus.instr_code[31:25];

   logic unused_instr;
   assign unused_instr = ^{bus.instr_code[24:15], bus.instr_code[11:7]};

`ifdef BUS_READY_EN
   assign mem_go = bus.dataMem_ready;
`else
   logic unused_ready;
   assign unused_ready = bus.dataMem_ready;
   assign mem_go       = 1'b1;
`endif

   assign legal_op = op inside {OP_TYPE_R, OP_TYPE_I, OP_TYPE_B, OP_TYPE_U, OP_TYPE_UA,
                                OP_TYPE_J, OP_TYPE_JI, OP_TYPE_S, OP_TYPE_IL};

   mcu_alu_decoder u_alu_decoder (
      .op          (op),
      .funct3      (funct3),
      .funct7      (funct7),
      .state       (state),
      .alu_control (alu_control)
   );

   // State register: every instruction returns to FETCH after its last state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RESET_STATE;
      end else begin
         case (state)
            FETCH:  state <= DECODE;
            DECODE: begin
               case (op)
                  OP_TYPE_R:  state <= R_EXE;
                  OP_TYPE_I:  state <= I_EXE;
                  OP_TYPE_B:  state <= B_EXE;
                  OP_TYPE_U:  state <= LU_EXE;
                  OP_TYPE_UA: state <= AU_EXE;
                  OP_TYPE_J:  state <= J_EXE;
                  OP_TYPE_JI: state <= JL_EXE;
                  OP_TYPE_S:  state <= S_EXE;
                  OP_TYPE_IL: state <= L_EXE;
                  default:    state <= FETCH;
               endcase
            end
            S_EXE:  state <= S_MEM;
            S_MEM:  if (mem_go) state <= FETCH;
            L_EXE:  state <= L_MEM;
            L_MEM:  if (mem_go) state <= L_WB;
            default: state <= FETCH;
         endcase
      end
   end

   // Moore decode of datapath controls; strobes are masked while reset is high
   // so nothing commits on the edge that samples reset.
   always_comb begin
      bus.pc_en                = 1'b0;
      bus.regFile_wr_en        = 1'b0;
      bus.AluSrcMuxSel         = 1'b0;
      bus.RFWriteDataSrcMuxSel = RFWD_ALU;
      bus.dataMem_wr_en        = 1'b0;
      bus.dataMem_req          = 1'b0;
      bus.immExtType           = IMM_I;
      bus.storeType            = 2'b00;
      bus.loadType             = 3'b000;
      bus.Bbranch              = 1'b0;
      bus.Jbranch              = 1'b0;
      bus.JIbranch             = 1'b0;
      bus.illegal_instr        = 1'b0;
      case (state)
         DECODE: if (!legal_op) begin
            bus.illegal_instr = 1'b1;
            bus.pc_en         = 1'b1;
         end
         R_EXE: begin
            bus.pc_en = 1'b1;  bus.regFile_wr_en = 1'b1;
         end
         I_EXE: begin
            bus.pc_en = 1'b1;  bus.regFile_wr_en = 1'b1;
            bus.AluSrcMuxSel = 1'b1;  bus.immExtType = IMM_IA;
         end
         B_EXE: begin
            bus.pc_en = 1'b1;  bus.immExtType = IMM_B;  bus.Bbranch = 1'b1;
         end
         LU_EXE: begin
            bus.pc_en = 1'b1;  bus.regFile_wr_en = 1'b1;
            bus.RFWriteDataSrcMuxSel = RFWD_IMM;  bus.immExtType = IMM_U;
         end
         AU_EXE: begin
            bus.pc_en = 1'b1;  bus.regFile_wr_en = 1'b1;
            bus.RFWriteDataSrcMuxSel = RFWD_PC;  bus.immExtType = IMM_U;
         end
         J_EXE: begin
            bus.pc_en = 1'b1;  bus.regFile_wr_en = 1'b1;
            bus.RFWriteDataSrcMuxSel = RFWD_PC;  bus.immExtType = IMM_J;
            bus.Jbranch = 1'b1;
         end
         JL_EXE: begin
            bus.pc_en = 1'b1;  bus.regFile_wr_en = 1'b1;
            bus.RFWriteDataSrcMuxSel = RFWD_PC;  bus.AluSrcMuxSel = 1'b1;
            bus.JIbranch = 1'b1;
         end
         S_EXE: begin
            bus.AluSrcMuxSel = 1'b1;  bus.immExtType = IMM_S;
            bus.storeType = funct3[1:0];
         end
         S_MEM: begin
            bus.AluSrcMuxSel = 1'b1;  bus.immExtType = IMM_S;
            bus.storeType = funct3[1:0];
            bus.dataMem_req = 1'b1;  bus.dataMem_wr_en = 1'b1;
            bus.pc_en = mem_go;
         end
         L_EXE: begin
            bus.AluSrcMuxSel = 1'b1;  bus.loadType = funct3;
         end
         L_MEM: begin
            bus.AluSrcMuxSel = 1'b1;  bus.loadType = funct3;  bus.dataMem_req = 1'b1;
         end
         L_WB: begin
            bus.AluSrcMuxSel = 1'b1;  bus.loadType = funct3;
            bus.regFile_wr_en = 1'b1;  bus.RFWriteDataSrcMuxSel = RFWD_LOAD;
            bus.pc_en = 1'b1;
         end
         default: bus.pc_en = 1'b0;
      endcase
      if (reset) begin
         bus.pc_en         = 1'b0;
         bus.regFile_wr_en = 1'b0;
         bus.dataMem_wr_en = 1'b0;
         bus.dataMem_req   = 1'b0;
         bus.illegal_instr = 1'b0;
      end
   end

   assign bus.ALUControl = alu_control;
   assign bus.state_o    = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed cases then random instructions.
module tb_multicycle_control_unit;
   import mcu_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic       pc;
      logic       rf;
      logic       asrc;
      logic [1:0] rfwd;
      logic       mwr;
      logic       mreq;
      logic [2:0] imm;
      logic [1:0] sty;
      logic [2:0] lty;
      logic       bb;
      logic       jb;
      logic       jib;
      logic [3:0] aluc;
      logic       ill;
   } ctl_t;

`ifdef BUS_READY_EN
   localparam bit READY_EN = 1'b1;
`else
   localparam bit READY_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_control_unit_if bus ();

   multicycle_control_unit #(.RESET_STATE(FETCH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   vectors     = 0;
   int   miscompares = 0;
   ctl_t exp_q[$];
   bit   rdy_q[$];

   function automatic ctl_t observe();
      ctl_t o;
      o.st   = bus.state_o;              o.pc   = bus.pc_en;
      o.rf   = bus.regFile_wr_en;        o.asrc = bus.AluSrcMuxSel;
      o.rfwd = bus.RFWriteDataSrcMuxSel; o.mwr  = bus.dataMem_wr_en;
      o.mreq = bus.dataMem_req;          o.imm  = bus.immExtType;
      o.sty  = bus.storeType;            o.lty  = bus.loadType;
      o.bb   = bus.Bbranch;              o.jb   = bus.Jbranch;
      o.jib  = bus.JIbranch;             o.aluc = bus.ALUControl;
      o.ill  = bus.illegal_instr;
      return o;
   endfunction

   task automatic check(input string tag, input ctl_t e);
      ctl_t o;
      o = observe();
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic check_vec(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111, 7'b0010111,
                        7'b1101111, 7'b1100111, 7'b0100011, 7'b0000011};
   endfunction

   // Expected per-cycle control vectors for one whole instruction, from the
   // instruction class: fetch, decode, then the class-specific tail.
   function automatic void build(input logic [31:0] ins, input int waits);
      ctl_t       e;
      logic [6:0] op  = ins[6:0];
      logic [2:0] f3  = ins[14:12];
      logic       f75 = ins[30];
      int         w   = READY_EN ? waits : 0;
      exp_q.delete();
      rdy_q.delete();
      e = '0;  e.st = FETCH;
      exp_q.push_back(e);  rdy_q.push_back(bit'($urandom_range(0, 1)));
      e = '0;  e.st = DECODE;
      if (!is_legal(op)) begin
         e.ill = 1'b1;  e.pc = 1'b1;
         exp_q.push_back(e);  rdy_q.push_back(bit'($urandom_range(0, 1)));
         return;
      end
      exp_q.push_back(e);  rdy_q.push_back(bit'($urandom_range(0, 1)));
      e = '0;
      if (op == 7'b0100011) begin
         e.st = S_EXE;  e.asrc = 1'b1;  e.imm = 3'b010;  e.sty = f3[1:0];
         exp_q.push_back(e);  rdy_q.push_back(bit'($urandom_range(0, 1)));
         e.st = S_MEM;  e.mreq = 1'b1;  e.mwr = 1'b1;
         for (int k = 0; k <= w; k++) begin
            e.pc = (k == w);
            exp_q.push_back(e);
            rdy_q.push_back(READY_EN ? (k == w) : bit'($urandom_range(0, 1)));
         end
      end else if (op == 7'b0000011) begin
         e.st = L_EXE;  e.asrc = 1'b1;  e.lty = f3;
         exp_q.push_back(e);  rdy_q.push_back(bit'($urandom_range(0, 1)));
         e.st = L_MEM;  e.mreq = 1'b1;
         for (int k = 0; k <= w; k++) begin
            exp_q.push_back(e);
            rdy_q.push_back(READY_EN ? (k == w) : bit'($urandom_range(0, 1)));
         end
         e.st = L_WB;  e.mreq = 1'b0;  e.rf = 1'b1;  e.rfwd = 2'b01;  e.pc = 1'b1;
         exp_q.push_back(e);  rdy_q.push_back(bit'($urandom_range(0, 1)));
      end else begin
         e.pc = 1'b1;  e.rf = 1'b1;
         case (op)
            7'b0110011: begin e.st = R_EXE;  e.aluc = {f75, f3}; end
            7'b0010011: begin
               e.st = I_EXE;  e.asrc = 1'b1;  e.imm = 3'b001;
               e.aluc = (f3[1:0] == 2'b01) ? {f75, f3} : {1'b0, f3};
            end
            7'b1100011: begin
               e.st = B_EXE;  e.rf = 1'b0;  e.imm = 3'b011;  e.bb = 1'b1;  e.aluc = {1'b0, f3};
            end
            7'b0110111: begin e.st = LU_EXE;  e.rfwd = 2'b10;  e.imm = 3'b100; end
            7'b0010111: begin e.st = AU_EXE;  e.rfwd = 2'b11;  e.imm = 3'b100; end
            7'b1101111: begin e.st = J_EXE;  e.rfwd = 2'b11;  e.imm = 3'b101;  e.jb = 1'b1; end
            default: begin
               e.st = JL_EXE;  e.rfwd = 2'b11;  e.asrc = 1'b1;  e.jib = 1'b1;  e.aluc = {1'b0, f3};
            end
         endcase
         exp_q.push_back(e);  rdy_q.push_back(bit'($urandom_range(0, 1)));
      end
   endfunction

   // Entered just after a rising edge with the DUT in FETCH; runs up to 'limit' cycles.
   task automatic run(input string tag, input logic [31:0] ins, input int waits, input int limit);
      int pcs = 0;
      int n;
      build(ins, waits);
      bus.instr_code = ins;
      n = (limit < exp_q.size()) ? limit : exp_q.size();
      for (int i = 0; i < n; i++) begin
         bus.dataMem_ready = rdy_q[i];
         @(negedge clk);
         check($sformatf("%s[%0d]", tag, i), exp_q[i]);
         pcs += int'(bus.pc_en);
         @(posedge clk);
         #1;
      end
      if (n == exp_q.size()) check_vec({tag, "_pc_once"}, 32'(pcs), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ctl_t        zero_fetch;
      logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b1100111, 7'b0100011, 7'b0000011};
      logic [6:0]  op;
      logic [31:0] ins;
      zero_fetch    = '0;
      zero_fetch.st = FETCH;

      reset = 1'b1;  bus.instr_code = 32'h0;  bus.dataMem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_state", zero_fetch);
      @(posedge clk);
      #1;
      reset = 1'b0;

      run("add",     32'h002081B3, 0, 99);
      run("lw",      32'h0040A283, 0, 99);
      run("sw_wait", 32'h0050A423, 3, 99);
      run("srai",    32'h4030D213, 0, 99);
      run("addi",    32'h00308213, 0, 99);
      run("illegal", 32'h0000007F, 0, 99);
      run("beq",     32'h00208463, 0, 99);
      run("jalr",    32'h000080E7, 0, 99);

      // Reset lands while the load sits in L_MEM.
      run("lw_rst", 32'h0040A283, 0, 3);
      reset = 1'b1;
      @(negedge clk);
      check_vec("rst_lmem_state", 32'(bus.state_o), 32'(L_MEM));
      check_vec("rst_lmem_rfwr", 32'(bus.regFile_wr_en), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_to_fetch", zero_fetch);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run("after_rst", 32'h00308213, 0, 99);

      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            op = 7'h7F;
            for (int k = 0; k < 50; k++) begin
               op = 7'($urandom);
               if (!is_legal(op)) break;
            end
            if (is_legal(op)) op = 7'h7F;
         end else begin
            op = ops[$urandom_range(0, 8)];
         end
         ins = {$urandom, 7'b0};
         ins[6:0] = op;
         run($sformatf("rnd%0d", t), ins, $urandom_range(0, 3), 99);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
